// File: rtl/ahb_console_wbuf_pkg.sv
// Purpose : shared register map and field positions for the console write buffer.
// Latency : n/a (constants only).
// Backpressure: n/a.
package ahb_console_wbuf_pkg;

  // Word offsets decoded from HADDR[3:2]
  localparam logic [1:0] DATA_OFS   = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] CTRL_OFS   = 2'd2;
  localparam logic [1:0] RSVD_OFS   = 2'd3;

  // STATUS register fields
  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_LEVEL_W   = 8;

  // CTRL register fields
  localparam int CTRL_FLUSH_BIT = 0;

endpackage

// File: rtl/ahb_console_wbuf_fifo.sv
// Purpose : synchronous byte FIFO with flush; head is the oldest entry, read combinationally.
// Latency : push visible at head one edge later (no bypass); level updates on the edge.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
// Ports   : HCLK/HRESETn clock and async active-low reset; push/push_data write side;
//           pop/head read side; flush clears; level/full/empty occupancy status.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [7:0]    head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ahb_console_wbuf.sv
// Purpose : AHB-Lite slave that buffers character writes and drains them to the console
//           font strobe whenever the console is not scrolling; STATUS/CTRL for software.
// Latency : byte pushed at edge E0 strobes to the console in the cycle after E1 at the earliest.
// Backpressure: HREADYOUT drops only for a DATA write while the FIFO is full; console_busy pauses draining.
// Ports   : HCLK/HRESETn; AHB-Lite slave (HSEL..HWDATA in, HRDATA/HREADYOUT out);
//           console_busy in; console_we/console_wdata strobe out; fifo_level occupancy out.
module ahb_console_wbuf
  import ahb_console_wbuf_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  input  logic          console_busy,
  output logic          console_we,
  output logic [7:0]    console_wdata,
  output logic [LW-1:0] fifo_level
);

  // Pending (data-phase) transfer captured from the address phase
  logic       ap_sel;
  logic       ap_write;
  logic       ap_trans1;
  logic [1:0] ap_addr;

  logic       xfer_active;
  logic       data_wr;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic [31:0] status_word;

  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_sel    <= 1'b0;
      ap_write  <= 1'b0;
      ap_trans1 <= 1'b0;
      ap_addr   <= 2'd0;
    end else if (HREADY) begin
      ap_sel    <= HSEL;
      ap_write  <= HWRITE;
      ap_trans1 <= HTRANS[1];
      ap_addr   <= HADDR[3:2];
    end
  end

  assign xfer_active = ap_sel & ap_trans1;
  assign data_wr     = xfer_active & ap_write & (ap_addr == DATA_OFS);

  // Full is judged before the edge, so a same-edge pop cannot release the stall early.
  assign HREADYOUT   = ~(data_wr & fifo_full);
  assign fifo_push   = data_wr & ~fifo_full;
  assign fifo_flush  = xfer_active & ap_write & (ap_addr == CTRL_OFS) & HWDATA[CTRL_FLUSH_BIT];
  // Flush takes priority over a would-be pop on the same edge.
  assign fifo_pop    = ~fifo_empty & ~console_busy & ~fifo_flush;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .push      (fifo_push),
    .push_data (HWDATA[7:0]),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      console_we    <= 1'b0;
      console_wdata <= 8'h00;
    end else begin
      console_we    <= fifo_pop;
      console_wdata <= fifo_pop ? fifo_head : 8'h00;
    end
  end

  always_comb begin
    status_word                                      = '0;
    status_word[STAT_EMPTY_BIT]                      = fifo_empty;
    status_word[STAT_FULL_BIT]                       = fifo_full;
    status_word[STAT_BUSY_BIT]                       = console_busy;
    status_word[STAT_LEVEL_LSB +: STAT_LEVEL_W]      = STAT_LEVEL_W'(fifo_level);
  end

  // Only STATUS reads return data; DATA, CTRL and the reserved slot read as zero.
  always_comb begin
    HRDATA = 32'h0;
    if (xfer_active && !ap_write && (ap_addr == STATUS_OFS)) HRDATA = status_word;
  end

endmodule

// File: tb/tb_ahb_console_wbuf.sv
module tb_ahb_console_wbuf;
  import ahb_console_wbuf_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          console_busy;
  logic          console_we;
  logic [7:0]    console_wdata;
  logic [LW-1:0] fifo_level;

  always #5 HCLK = ~HCLK;

  // Single-slave bus: the interconnect feeds our own ready back as HREADY.
  assign HREADY = HREADYOUT;

  ahb_console_wbuf #(.DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .console_busy(console_busy), .console_we(console_we),
    .console_wdata(console_wdata), .fifo_level(fifo_level)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int strobes = 0;
  int stalls;
  int max_level = 0;
  logic busy_prev = 1'b0;
  logic [7:0] sb[$];
  int strobe_cyc[$];
  int push_cyc[$];

  logic        xw [64];
  logic [1:0]  xa [64];
  logic [31:0] xd [64];
  logic [31:0] xr [64];

  typedef struct {
    int          fill;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vtab [7];

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected byte, and
  // no strobe may follow an edge at which the console reported busy.
  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (console_we) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL strobe_unexpected: got byte %h, expected no strobe", console_wdata);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (console_wdata !== e) begin
            miscompares++;
            $display("FAIL strobe_data: got %h, expected %h", console_wdata, e);
          end
        end
        if (busy_prev) begin
          miscompares++;
          $display("FAIL strobe_while_busy: got strobe %h, expected none", console_wdata);
        end
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
    busy_prev = console_busy;
  end

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'h0;
  endtask

  // Pipelined transfers from xw/xa/xd; read data lands in xr. Called #1 after a posedge.
  task automatic run_xfers(input int n);
    bit rdy;
    int to;
    logic [31:0] rd;
    stalls = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = xw[i]; HADDR = {28'h0, xa[i], 2'b00};
      end else begin
        bus_idle();
      end
      if (i > 0) HWDATA = xw[i-1] ? xd[i-1] : 32'h0;
      rdy = 1'b0; to = 0; rd = '0;
      while (!rdy && to < 200) begin
        @(negedge HCLK);
        rdy = HREADYOUT;
        rd  = HRDATA;
        @(posedge HCLK); #1;
        if (!rdy) begin stalls++; to++; end
      end
      if (!rdy) chk("xfer_timeout", 32'(rdy), 32'd1);
      if (i > 0) begin
        xr[i-1] = rd;
        if (xw[i-1] && xa[i-1] == DATA_OFS) begin
          sb.push_back(xd[i-1][7:0]);
          push_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      xw[i] = 1'b1; xa[i] = DATA_OFS; xd[i] = {24'h0, base + 8'(i)};
    end
    run_xfers(n);
  endtask

  task automatic single(input logic w, input logic [1:0] a, input logic [31:0] d);
    xw[0] = w; xa[0] = a; xd[0] = d;
    run_xfers(1);
  endtask

  task automatic wait_drain(input string name);
    int to;
    to = 0;
    while (!(sb.size() == 0 && fifo_level == '0 && !console_we) && to < 300) begin
      @(posedge HCLK); #1; to++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge HCLK); #1; end
  endtask

  initial begin
    int base;
    int s1;
    bus_idle();
    HWDATA = 32'h0; console_busy = 1'b0; HRESETn = 1'b0;

    // Reset state
    #12;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_we", 32'(console_we), 32'd0);
    chk("rst_wdata", 32'(console_wdata), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    idle_cycles(2);

    // 1: three back-to-back writes, consecutive strobes, one-cycle-after-E1 latency
    strobe_cyc.delete(); push_cyc.delete(); base = strobes;
    write_bytes(3, 8'h41);
    wait_drain("t1_drain");
    chk("t1_count", 32'(strobes - base), 32'd3);
    if (strobe_cyc.size() >= 3 && push_cyc.size() >= 1) begin
      chk("t1_latency", 32'(strobe_cyc[0] - push_cyc[0]), 32'd1);
      chk("t1_consecutive", 32'(strobe_cyc[2] - strobe_cyc[0]), 32'd2);
    end else chk("t1_strobe_log", 32'(strobe_cyc.size()), 32'd3);
    chk("t1_level", 32'(fifo_level), 32'd0);

    // Table: fill with busy=1, read a register, then flush
    vtab[0] = '{0,  STATUS_OFS, 32'h0000_0005};
    vtab[1] = '{1,  STATUS_OFS, 32'h0000_0104};
    vtab[2] = '{15, STATUS_OFS, 32'h0000_0F04};
    vtab[3] = '{16, STATUS_OFS, 32'h0000_1006};
    vtab[4] = '{3,  DATA_OFS,   32'h0000_0000};
    vtab[5] = '{3,  CTRL_OFS,   32'h0000_0000};
    vtab[6] = '{3,  RSVD_OFS,   32'h0000_0000};
    console_busy = 1'b1;
    for (int v = 0; v < 7; v++) begin
      write_bytes(vtab[v].fill, 8'h60);
      chk($sformatf("tab%0d_stalls", v), 32'(stalls), 32'd0);
      chk($sformatf("tab%0d_level", v), 32'(fifo_level), 32'(vtab[v].fill));
      single(1'b0, vtab[v].rd_addr, 32'h0);
      chk($sformatf("tab%0d_rdata", v), xr[0], vtab[v].exp_rdata);
      single(1'b1, CTRL_OFS, 32'h1);
      sb.delete();
      single(1'b0, STATUS_OFS, 32'h0);
      chk($sformatf("tab%0d_flushed", v), xr[0], 32'h0000_0005);
    end

    // 2: 16 bytes while busy, 17th stalls until busy drops
    base = strobes;
    write_bytes(16, 8'h00);
    chk("t2_nostall", 32'(stalls), 32'd0);
    single(1'b0, STATUS_OFS, 32'h0);
    chk("t2_status", xr[0], 32'h0000_1006);
    fork
      single(1'b1, DATA_OFS, 32'h10);
      begin
        idle_cycles(5);
        chk("t2_stalled", 32'(HREADYOUT), 32'd0);
        console_busy = 1'b0;
      end
    join
    chk("t2_stall_cycles", 32'(stalls), 32'd5);
    wait_drain("t2_drain");
    chk("t2_count", 32'(strobes - base), 32'd17);

    // 3: busy pulse of 5 cycles in the middle of an 8-byte drain
    base = strobes; s1 = 0;
    fork
      write_bytes(8, 8'hA0);
      begin
        int to;
        to = 0;
        while (strobes - base < 2 && to < 100) begin @(posedge HCLK); #1; to++; end
        console_busy = 1'b1;
        idle_cycles(1);
        s1 = strobes;
        idle_cycles(4);
        console_busy = 1'b0;
        chk("t3_pause", 32'(strobes - s1), 32'd0);
      end
    join
    wait_drain("t3_drain");
    chk("t3_count", 32'(strobes - base), 32'd8);

    // 4: flush 10 queued bytes, then a lone byte
    base = strobes;
    console_busy = 1'b1;
    write_bytes(10, 8'hC0);
    single(1'b1, CTRL_OFS, 32'h1);
    sb.delete();
    chk("t4_level", 32'(fifo_level), 32'd0);
    single(1'b0, STATUS_OFS, 32'h0);
    chk("t4_status", xr[0], 32'h0000_0005);
    console_busy = 1'b0;
    idle_cycles(6);
    chk("t4_nostrobe", 32'(strobes - base), 32'd0);
    write_bytes(1, 8'h55);
    wait_drain("t4_drain");
    chk("t4_lone", 32'(strobes - base), 32'd1);

    // Flush on the same edge a pop would otherwise happen: flush wins
    base = strobes;
    console_busy = 1'b1;
    write_bytes(4, 8'hD0);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, CTRL_OFS, 2'b00};
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = 32'h1; console_busy = 1'b0;
    @(posedge HCLK); #1;
    sb.delete();
    chk("fp_level", 32'(fifo_level), 32'd0);
    idle_cycles(4);
    chk("fp_nostrobe", 32'(strobes - base), 32'd0);

    // 5: asynchronous reset with a full FIFO and a stalled write
    base = strobes;
    console_busy = 1'b1;
    write_bytes(16, 8'h20);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, DATA_OFS, 2'b00};
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = 32'h77;
    idle_cycles(2);
    chk("t5_stalled", 32'(HREADYOUT), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("t5_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("t5_rst_we", 32'(console_we), 32'd0);
    chk("t5_rst_level", 32'(fifo_level), 32'd0);
    sb.delete();
    console_busy = 1'b0;
    idle_cycles(2);
    HRESETn = 1'b1;
    idle_cycles(10);
    chk("t5_nostale", 32'(strobes - base), 32'd0);

    // 6: 40 writes with random busy, exercising pointer wrap
    base = strobes; max_level = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          xw[i] = 1'b1; xa[i] = DATA_OFS; xd[i] = 32'((i * 7 + 3) & 8'hFF);
        end
        run_xfers(40);
      end
      begin
        repeat (60) begin
          @(posedge HCLK); #1;
          console_busy = ($urandom_range(0, 3) != 0);
        end
        console_busy = 1'b0;
      end
    join
    wait_drain("t6_drain");
    chk("t6_count", 32'(strobes - base), 32'd40);
    chk("t6_max_level_ok", 32'(max_level <= DEPTH), 32'd1);
    xw[0] = 1'b0; xa[0] = DATA_OFS;
    xw[1] = 1'b0; xa[1] = CTRL_OFS;
    xw[2] = 1'b0; xa[2] = RSVD_OFS;
    run_xfers(3);
    chk("t6_rd_data", xr[0], 32'h0);
    chk("t6_rd_ctrl", xr[1], 32'h0);
    chk("t6_rd_rsvd", xr[2], 32'h0);

    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
